// File: rtl/hold_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hold_sweep_ctrl
// Description : Hold-time characterisation sequencer for a flip-flop under
//               test. For every (clock-slew, data-slew) index pair it runs a
//               series of trials. Each trial drives a data pulse that rises
//               SETUP_TICKS before the rising DUT-clock edge. The pulse stays
//               high for i*STEP_TICKS after that edge. The captured output is
//               then sampled. The first trial index i whose capture reads 1 is
//               reported for the pair.
//
// Ports
//   clk        in   system clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to run a full sweep (ignored when busy)
//   dut_q      in   captured output of the flop under test (asynchronous)
//   dut_clk    out  generated DUT clock
//   dut_d      out  generated DUT data
//   ck_idx     out  current clock-slew index
//   d_idx      out  current data-slew index
//   busy       out  sweep in progress
//   res_valid  out  one-cycle result strobe
//   res_step   out  first passing trial index for (ck_idx, d_idx)
//   res_found  out  1 = a passing trial was found
//   done       out  one-cycle pulse at sweep end
//
// Revision    : 1.0  initial release
// ============================================================================
module hold_sweep_ctrl #(
    parameter int HALF_TICKS     = 1000,
    parameter int SETUP_TICKS    = 50,
    parameter int STEP_TICKS     = 1,
    parameter int NSTEPS         = 501,
    parameter int NB_CK          = 3,
    parameter int NB_D           = 3,
    parameter int SETTLE_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_q,
    output logic       dut_clk,
    output logic       dut_d,
    output logic [1:0] ck_idx,
    output logic [1:0] d_idx,
    output logic       busy,
    output logic       res_valid,
    output logic [8:0] res_step,
    output logic       res_found,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    // Tick counter reaches 2*HALF_TICKS-1; the width also holds 2*HALF_TICKS.
    localparam int T_W = $clog2(2 * HALF_TICKS + 1);
    // Trial index reaches NSTEPS-1; the width also holds NSTEPS.
    localparam int I_W = $clog2(NSTEPS + 1);
    // Settle-period counter; at least one bit even for a single period.
    localparam int P_W = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;

    localparam logic [T_W-1:0] c_T_LAST = T_W'(2 * HALF_TICKS - 1);
    localparam logic [T_W-1:0] c_T_HALF = T_W'(HALF_TICKS);
    localparam logic [T_W-1:0] c_T_RISE = T_W'(HALF_TICKS - SETUP_TICKS);
    localparam logic [T_W-1:0] c_T_STEP = T_W'(STEP_TICKS);
    localparam logic [T_W-1:0] c_T_ONE  = T_W'(1);
    localparam logic [I_W-1:0] c_I_LAST = I_W'(NSTEPS - 1);
    localparam logic [I_W-1:0] c_I_ONE  = I_W'(1);
    localparam logic [P_W-1:0] c_P_LAST = P_W'((SETTLE_PERIODS > 0) ? SETTLE_PERIODS - 1 : 0);
    localparam logic [P_W-1:0] c_P_ONE  = P_W'(1);
    localparam logic [1:0]     c_CK_LAST = 2'(NB_CK - 1);
    localparam logic [1:0]     c_D_LAST  = 2'(NB_D - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_TRIAL  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]     r_state;
    logic [T_W-1:0] r_t;          // tick within the current DUT period
    logic [P_W-1:0] r_per;        // completed settle periods
    logic [I_W-1:0] r_i;          // current trial index
    logic [T_W-1:0] r_fall;       // tick at which the data pulse ends
    logic           r_to_settle;  // CLEAR leads into SETTLE, not TRIAL
    logic           r_sync1;
    logic           r_sync2;
    logic           r_sample;

    logic           r_dut_clk;
    logic           r_dut_d;
    logic [1:0]     r_ck_idx;
    logic [1:0]     r_d_idx;
    logic           r_busy;
    logic           r_res_valid;
    logic [8:0]     r_res_step;
    logic           r_res_found;
    logic           r_done;

    // ------------------------------------------------------------------------
    // Tick decode. Output waveforms are registered copies of these, so both
    // DUT pins lag the tick counter by the same single cycle and their
    // relative timing is exact.
    // ------------------------------------------------------------------------
    logic w_t_wrap;
    logic w_clk_hi;
    logic w_d_hi;

    assign w_t_wrap = (r_t == c_T_LAST);
    assign w_clk_hi = (r_t >= c_T_HALF);
    assign w_d_hi   = (r_t >= c_T_RISE) && (r_t < r_fall);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_per       <= '0;
            r_i         <= '0;
            r_fall      <= '0;
            r_to_settle <= 1'b0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sample    <= 1'b0;
            r_dut_clk   <= 1'b0;
            r_dut_d     <= 1'b0;
            r_ck_idx    <= 2'd0;
            r_d_idx     <= 2'd0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_step  <= 9'd0;
            r_res_found <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Two-stage synchronizer for the asynchronous capture output.
            r_sync1 <= dut_q;
            r_sync2 <= r_sync1;

            // Strobes and DUT pins default low; states below raise them.
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            r_dut_clk   <= 1'b0;
            r_dut_d     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ck_idx <= 2'd0;
                        r_d_idx  <= 2'd0;
                        r_i      <= '0;
                        r_fall   <= c_T_HALF;
                        r_t      <= '0;
                        r_per    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETTLE;
                    end
                end

                // Data held low while the DUT clock runs, letting the new
                // slew settings settle.
                S_SETTLE: begin
                    r_dut_clk <= w_clk_hi;
                    if (w_t_wrap) begin
                        r_t <= '0;
                        if (r_per == c_P_LAST) begin
                            r_per   <= '0;
                            r_state <= S_TRIAL;
                        end else begin
                            r_per <= r_per + c_P_ONE;
                        end
                    end else begin
                        r_t <= r_t + c_T_ONE;
                    end
                end

                // The capture happened at mid-period; by the last tick the
                // synchronized output has long been stable.
                S_TRIAL: begin
                    r_dut_clk <= w_clk_hi;
                    r_dut_d   <= w_d_hi;
                    if (w_t_wrap) begin
                        r_t      <= '0;
                        r_sample <= r_sync2;
                        r_state  <= S_CHECK;
                    end else begin
                        r_t <= r_t + c_T_ONE;
                    end
                end

                // The result registers are loaded together with the strobe,
                // so they hold the previous result right up to this strobe.
                S_CHECK: begin
                    if (r_sample) begin
                        r_res_step  <= 9'(r_i);
                        r_res_found <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else if (r_i != c_I_LAST) begin
                        r_i         <= r_i + c_I_ONE;
                        r_fall      <= r_fall + c_T_STEP;
                        r_to_settle <= 1'b0;
                        r_state     <= S_CLEAR;
                    end else begin
                        r_res_step  <= 9'(c_I_LAST);
                        r_res_found <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end
                end

                // Full period with data low so the flop re-captures 0 before
                // the next trial.
                S_CLEAR: begin
                    r_dut_clk <= w_clk_hi;
                    if (w_t_wrap) begin
                        r_t     <= '0;
                        r_state <= r_to_settle ? S_SETTLE : S_TRIAL;
                    end else begin
                        r_t <= r_t + c_T_ONE;
                    end
                end

                // The terminal branch of the index advance is resolved here so
                // that done follows the final strobe directly; indices then
                // keep the last pair.
                S_RESULT: begin
                    if ((r_ck_idx == c_CK_LAST) && (r_d_idx == c_D_LAST)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (r_d_idx == c_D_LAST) begin
                        r_d_idx  <= 2'd0;
                        r_ck_idx <= r_ck_idx + 2'd1;
                    end else begin
                        r_d_idx <= r_d_idx + 2'd1;
                    end
                    r_i         <= '0;
                    r_fall      <= c_T_HALF;
                    r_t         <= '0;
                    r_to_settle <= 1'b1;
                    r_state     <= S_CLEAR;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dut_clk   = r_dut_clk;
    assign dut_d     = r_dut_d;
    assign ck_idx    = r_ck_idx;
    assign d_idx     = r_d_idx;
    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign res_step  = r_res_step;
    assign res_found = r_res_found;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hold_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hold_sweep_ctrl
// Description : Self-checking bench for hold_sweep_ctrl. A behavioural flop
//               captures dut_d on rising dut_clk and only keeps a 1 when the
//               data stays high for at least Th clk cycles after the edge.
//               Th is chosen per (ck_idx, d_idx) pair. Expected results are
//               queued per sweep and compared as res_valid strobes arrive.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hold_sweep_ctrl;

    localparam int H      = 64;
    localparam int SETUP  = 8;
    localparam int STEP   = 1;
    localparam int NSTEPS = 32;
    localparam int NBCK   = 2;
    localparam int NBD    = 2;
    localparam int SETTLE = 1;

    typedef struct packed {
        logic [1:0] ck;
        logic [1:0] d;
        logic [8:0] step;
        logic       found;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dut_q;
    logic       dut_clk;
    logic       dut_d;
    logic [1:0] ck_idx;
    logic [1:0] d_idx;
    logic       busy;
    logic       res_valid;
    logic [8:0] res_step;
    logic       res_found;
    logic       done;

    hold_sweep_ctrl #(
        .HALF_TICKS    (H),
        .SETUP_TICKS   (SETUP),
        .STEP_TICKS    (STEP),
        .NSTEPS        (NSTEPS),
        .NB_CK         (NBCK),
        .NB_D          (NBD),
        .SETTLE_PERIODS(SETTLE)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dut_q    (dut_q),
        .dut_clk  (dut_clk),
        .dut_d    (dut_d),
        .ck_idx   (ck_idx),
        .d_idx    (d_idx),
        .busy     (busy),
        .res_valid(res_valid),
        .res_step (res_step),
        .res_found(res_found),
        .done     (done)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   th_tab[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural flop under test with a per-pair hold requirement
    // ------------------------------------------------------------------------
    logic model_q = 1'b0;
    assign dut_q = model_q;

    always begin
        int   th;
        logic cap;
        @(posedge dut_clk);
        th  = th_tab[{ck_idx[0], d_idx[0]}];
        cap = 1'b1;
        for (int k = 0; k < th; k++) begin
            @(negedge clk);
            if (dut_d !== 1'b1) cap = 1'b0;
        end
        model_q = cap;
    end

    // ------------------------------------------------------------------------
    // Output monitor / scoreboard (samples on the falling edge)
    // ------------------------------------------------------------------------
    int   cyc = 0;
    int   n_valid = 0;
    int   n_done = 0;
    int   last_valid_cyc = 0;
    int   done_cyc = 0;
    int   d_rises = 0;
    int   t_drise = -1;
    int   t_crise = -1;
    int   t_dfall = -1;
    logic prev_d = 1'b0;
    logic prev_c = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (res_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            check("res_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_ck_idx", 32'(ck_idx), 32'(e.ck));
                check("res_d_idx", 32'(d_idx), 32'(e.d));
                check("res_step", 32'(res_step), 32'(e.step));
                check("res_found", 32'(res_found), 32'(e.found));
            end
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'd0);
        end
        if (dut_d === 1'b1 && prev_d === 1'b0) begin
            d_rises++;
            if (d_rises == 3) t_drise = cyc;
        end
        if (dut_clk === 1'b1 && prev_c === 1'b0 && t_drise >= 0 && t_crise < 0) t_crise = cyc;
        if (dut_d === 1'b0 && prev_d === 1'b1 && t_crise >= 0 && t_dfall < 0) t_dfall = cyc;
        prev_d = dut_d;
        prev_c = dut_clk;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic push_run();
        exp_t e;
        for (int c = 0; c < NBCK; c++) begin
            for (int d = 0; d < NBD; d++) begin
                int th;
                th      = th_tab[c * 2 + d];
                e.ck    = 2'(c);
                e.d     = 2'(d);
                e.found = (th <= NSTEPS - 1);
                e.step  = e.found ? 9'(th) : 9'(NSTEPS - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int got;
        d0  = n_done;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (n_done != d0) begin
                got = 1;
                break;
            end
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dut_clk"}, 32'(dut_clk), 32'd0);
        check({tag, "_dut_d"}, 32'(dut_d), 32'd0);
        check({tag, "_ck_idx"}, 32'(ck_idx), 32'd0);
        check({tag, "_d_idx"}, 32'(d_idx), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_step"}, 32'(res_step), 32'd0);
        check({tag, "_res_found"}, 32'(res_found), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int v0;
        int d0;
        int got;

        rst   = 1'b1;
        start = 1'b0;
        th_tab = '{3, 5, 7, 9};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // ---- Run A: thresholds 3/5/7/9, stray start while busy -------------
        d_rises = 0;
        t_drise = -1;
        t_crise = -1;
        t_dfall = -1;
        push_run();
        v0 = n_valid;
        d0 = n_done;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        got = 0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            if (n_valid != v0) begin
                got = 1;
                break;
            end
        end
        check("runA_first_result", 32'(got), 32'd1);
        pulse_start();
        wait_done("runA_done", 40000);
        repeat (4) @(posedge clk);
        check("runA_result_count", 32'(n_valid - v0), 32'd4);
        check("runA_queue_empty", 32'(exp_q.size()), 32'd0);
        check("runA_done_after_strobe", 32'(done_cyc - last_valid_cyc), 32'd1);
        check("runA_done_pulses", 32'(n_done - d0), 32'd1);
        @(negedge clk);
        check("runA_busy_idle", 32'(busy), 32'd0);
        check("runA_ck_hold", 32'(ck_idx), 32'd1);
        check("runA_d_hold", 32'(d_idx), 32'd1);
        check("trial2_setup_ticks", 32'(t_crise - t_drise), 32'(SETUP));
        check("trial2_hold_ticks", 32'(t_dfall - t_crise), 32'(2 * STEP));

        // ---- Run B: pair (0,1) never passes --------------------------------
        th_tab = '{3, 40, 7, 9};
        push_run();
        v0 = n_valid;
        pulse_start();
        wait_done("runB_done", 60000);
        repeat (4) @(posedge clk);
        check("runB_result_count", 32'(n_valid - v0), 32'd4);
        check("runB_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---- Run C: reset during pair (1,0), then a clean rerun ------------
        th_tab = '{3, 5, 7, 9};
        push_run();
        v0 = n_valid;
        d0 = n_done;
        pulse_start();
        got = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (ck_idx === 2'd1 && d_idx === 2'd0) begin
                got = 1;
                break;
            end
        end
        check("runC_reached_pair10", 32'(got), 32'd1);
        repeat (200) @(negedge clk);
        check("runC_results_before_rst", 32'(n_valid - v0), 32'd2);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst   = 1'b0;
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_no_result", 32'(n_valid - v0), 32'd2);
        check("midrst_pending", 32'(exp_q.size()), 32'd2);
        exp_q.delete();

        push_run();
        v0 = n_valid;
        pulse_start();
        wait_done("runC_done", 40000);
        repeat (4) @(posedge clk);
        check("runC_result_count", 32'(n_valid - v0), 32'd4);
        check("runC_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
